// File: rtl/pixel_pack_fifo_if.sv
// Stream bundle between the pixel pipeline, the packing FIFO and the downstream reader.
// The master side drives pixels and the read handshake. The slave side is the FIFO.
interface pixel_pack_fifo_if;
  logic        in_valid;
  logic [31:0] in_pixel;
  logic [4:0]  shift_amt;
  logic        flush;
  logic        clr_status;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_valid, in_pixel, shift_amt, flush, clr_status, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_valid, in_pixel, shift_amt, flush, clr_status, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/pixel_pack_fifo.sv
// Normalises 32-bit processed pixels to clamped bytes, packs four per word (oldest in [7:0])
// and queues the words in a show-ahead FIFO drained through a ready/valid reader.
module pixel_pack_fifo #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  pixel_pack_fifo_if.slave bus,
  output logic [ADDR_W:0]  level,
  output logic [1:0]       byte_cnt,
  output logic             overflow,
  output logic             sat_seen
);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic signed [31:0] shifted;
  logic [7:0]         pix_byte;
  logic               sat_evt;
  logic [31:0]        pack_q, pack_d, pack_wr;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic               push, pop, full, wr_en, ovf_evt;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    level_q, level_d;
  logic               out_valid_q, overflow_q, overflow_d, sat_q, sat_d;
  logic [31:0]        mem_q [DEPTH];

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    shifted  = $signed(bus.in_pixel) >>> bus.shift_amt;
    pix_byte = shifted[7:0];
    sat_evt  = 1'b0;
    if (shifted < 0) begin
      pix_byte = 8'h00;
      sat_evt  = bus.in_valid;
    end else if (shifted > 255) begin
      pix_byte = 8'hFF;
      sat_evt  = bus.in_valid;
    end
  end

  // Lanes above byte_cnt are always zero, so a flushed partial word is already zero-padded.
  always_comb begin
    pack_wr = pack_q;
    if (bus.in_valid) pack_wr[{byte_cnt_q, 3'b000} +: 8] = pix_byte;
    push = (bus.in_valid && byte_cnt_q == 2'd3) ||
           (bus.flush && (byte_cnt_q != 2'd0 || bus.in_valid));
    if (push) begin
      pack_d     = '0;
      byte_cnt_d = 2'd0;
    end else begin
      pack_d     = pack_wr;
      byte_cnt_d = bus.in_valid ? byte_cnt_q + 2'd1 : byte_cnt_q;
    end
  end

  // A full FIFO still takes a word when the head leaves in the same cycle.
  always_comb begin
    pop      = out_valid_q && bus.out_ready;
    full     = (level_q == FULL_LVL);
    wr_en    = push && (!full || pop);
    ovf_evt  = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, pop};
    overflow_d = (overflow_q && !bus.clr_status) || ovf_evt;
    sat_d      = (sat_q && !bus.clr_status) || sat_evt;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q      <= '0;
      byte_cnt_q  <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      byte_cnt_q  <= byte_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= (level_d != '0);
      overflow_q  <= overflow_d;
      sat_q       <= sat_d;
    end
  end

  // NOTE: storage has no reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pack_wr;
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = out_valid_q;
  assign level         = level_q;
  assign byte_cnt      = byte_cnt_q;
  assign overflow      = overflow_q;
  assign sat_seen      = sat_q;
endmodule

// File: tb/tb_pixel_pack_fifo.sv
// Directed and randomized bench for pixel_pack_fifo, checked against a queue-based
// reference model that works on whole bytes and words rather than pointers.
module tb_pixel_pack_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst;
  logic [ADDR_W:0] level;
  logic [1:0]      byte_cnt;
  logic            overflow, sat_seen;

  pixel_pack_fifo_if bus_if();

  pixel_pack_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .level    (level),
    .byte_cnt (byte_cnt),
    .overflow (overflow),
    .sat_seen (sat_seen)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]  m_pend[$];
  logic [31:0] m_q[$];
  bit          m_ovf, m_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic shift of a non-negative value is floor division; any negative value stays negative.
  function automatic logic [7:0] norm(input logic [31:0] px, input int sh, output bit sat);
    longint v;
    v = longint'($signed(px));
    sat = 1'b0;
    if (v < 0) begin
      sat = 1'b1;
      return 8'h00;
    end
    v = v / (longint'(1) << sh);
    if (v > 255) begin
      sat = 1'b1;
      return 8'hFF;
    end
    return v[7:0];
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".level"},     32'(level),              32'(m_q.size()));
    check({tag, ".out_valid"}, 32'(bus_if.out_valid),   32'(m_q.size() != 0));
    check({tag, ".byte_cnt"},  32'(byte_cnt),           32'(m_pend.size()));
    check({tag, ".overflow"},  32'(overflow),           32'(m_ovf));
    check({tag, ".sat_seen"},  32'(sat_seen),           32'(m_sat));
    if (m_q.size() != 0) check({tag, ".out_data"}, bus_if.out_data, m_q[0]);
  endtask

  task automatic step(input string tag, input bit v, input logic [31:0] px, input logic [4:0] sh,
                      input bit fl, input bit clr, input bit rdy);
    bit          s_evt, o_evt, pop, push;
    logic [7:0]  b;
    logic [31:0] w;
    bus_if.in_valid   = v;
    bus_if.in_pixel   = px;
    bus_if.shift_amt  = sh;
    bus_if.flush      = fl;
    bus_if.clr_status = clr;
    bus_if.out_ready  = rdy;
    s_evt = 1'b0;
    o_evt = 1'b0;
    pop   = rdy && (m_q.size() != 0);
    if (v) begin
      b = norm(px, int'(sh), s_evt);
      m_pend.push_back(b);
    end
    push = (m_pend.size() == 4) || (fl && m_pend.size() != 0);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      w = 32'h0;
      foreach (m_pend[i]) w = w | (32'(m_pend[i]) << (8 * i));
      m_pend.delete();
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else o_evt = 1'b1;
    end
    m_sat = (m_sat && !clr) || s_evt;
    m_ovf = (m_ovf && !clr) || o_evt;
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic pix(input string tag, input logic [31:0] px, input logic [4:0] sh, input bit rdy);
    step(tag, 1'b1, px, sh, 1'b0, 1'b0, rdy);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus_if.in_valid   = 1'b0;
    bus_if.in_pixel   = 32'h0;
    bus_if.shift_amt  = 5'd0;
    bus_if.flush      = 1'b0;
    bus_if.clr_status = 1'b0;
    bus_if.out_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pend.delete();
    m_q.delete();
    m_ovf = 1'b0;
    m_sat = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] px;
    logic [4:0]  sh;
    int          rdy_pct;

    // 1: basic packing and one-cycle latency
    do_reset("rst0");
    pix("t1", 32'd1, 5'd0, 1'b0);
    pix("t1", 32'd2, 5'd0, 1'b0);
    pix("t1", 32'd3, 5'd0, 1'b0);
    check("t1.pre_valid", 32'(bus_if.out_valid), 32'd0);
    pix("t1", 32'd4, 5'd0, 1'b0);
    check("t1.word", bus_if.out_data, 32'h04030201);
    check("t1.level1", 32'(level), 32'd1);
    idle("t1.pop", 1'b1);

    // 2: clamping both ways and sticky clear
    pix("t2", -32'sd5, 5'd0, 1'b0);
    pix("t2", 32'd300, 5'd0, 1'b0);
    pix("t2", 32'd128, 5'd0, 1'b0);
    pix("t2", 32'd7,   5'd0, 1'b0);
    check("t2.word", bus_if.out_data, 32'h0780FF00);
    check("t2.sat", 32'(sat_seen), 32'd1);
    step("t2.clr", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("t2.sat_clr", 32'(sat_seen), 32'd0);
    // set beats clear in the same cycle
    step("t2.setwin", 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, 1'b0);
    check("t2.setwin_sat", 32'(sat_seen), 32'd1);
    step("t2.clr2", 1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0);
    idle("t2.pop", 1'b1);

    // 3: shift before clamp
    pix("t3", 32'h0000_0FF0, 5'd4, 1'b0);
    pix("t3", 32'h0000_0800, 5'd4, 1'b0);
    pix("t3", 32'h0000_1000, 5'd4, 1'b0);
    pix("t3", 32'h8000_0000, 5'd31, 1'b0);
    check("t3.word", bus_if.out_data, 32'h00FF80FF);
    idle("t3.pop", 1'b1);

    // 4: partial flush, then flush alone is a no-op
    pix("t4", 32'd9,  5'd0, 1'b0);
    pix("t4", 32'd10, 5'd0, 1'b0);
    step("t4.flush", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("t4.word", bus_if.out_data, 32'h00000A09);
    check("t4.bcnt", 32'(byte_cnt), 32'd0);
    step("t4.noop", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("t4.level", 32'(level), 32'd1);
    step("t4.flush_px", 1'b1, 32'd77, 5'd0, 1'b1, 1'b0, 1'b1);
    idle("t4.pop", 1'b1);

    // 5: overflow, full push+pop, ordered drain across wrap
    for (int w = 0; w < DEPTH + 1; w++)
      for (int k = 0; k < 4; k++) pix("t5.fill", 32'($urandom_range(255)), 5'd0, 1'b0);
    check("t5.level_full", 32'(level), 32'(DEPTH));
    check("t5.ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < 3; k++) pix("t5.fp", 32'($urandom_range(255)), 5'd0, 1'b0);
    pix("t5.fp", 32'($urandom_range(255)), 5'd0, 1'b1);
    check("t5.level_pp", 32'(level), 32'(DEPTH));
    for (int k = 0; k < DEPTH + 2; k++) idle("t5.drain", 1'b1);
    check("t5.empty", 32'(level), 32'd0);

    // 6: reset discards partial bytes and queued words
    step("t6.clr", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) pix("t6.fill", 32'($urandom_range(255)), 5'd0, 1'b0);
    do_reset("t6.rst");
    check("t6.level", 32'(level), 32'd0);
    check("t6.bcnt", 32'(byte_cnt), 32'd0);
    check("t6.valid", 32'(bus_if.out_valid), 32'd0);
    pix("t6", 32'h11, 5'd0, 1'b0);
    pix("t6", 32'h22, 5'd0, 1'b0);
    pix("t6", 32'h33, 5'd0, 1'b0);
    pix("t6", 32'h44, 5'd0, 1'b0);
    check("t6.word", bus_if.out_data, 32'h44332211);

    // randomized traffic: slow reader first to reach full, then a fast one
    for (int c = 0; c < 1200; c++) begin
      rdy_pct = (c < 500) ? 15 : 80;
      case ($urandom_range(3))
        0:       px = $urandom;
        1:       px = 32'($urandom_range(700)) - 32'd200;
        2:       px = 32'($urandom_range(255));
        default: px = 32'($urandom_range(65535));
      endcase
      sh = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(4));
      step("rnd", $urandom_range(9) < 7, px, sh, $urandom_range(15) == 0,
           $urandom_range(31) == 0, $urandom_range(99) < rdy_pct);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
